// File: rtl/reg_write_queue.sv
// Write-request FIFO feeding a register bank: one-hot enable plus broadcast data per drained entry.
// Optional occupancy output `level` when WRQ_LEVEL_EN is defined.
module reg_write_queue #(
    parameter int W     = 8,
    parameter int N     = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [W-1:0]  in_data,
    input  logic          hold,
    output logic [N-1:0]  en_out,
    output logic [W-1:0]  d_out,
    output logic          addr_err
`ifdef WRQ_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW:0] N_EXT = (AW+1)'(N);

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [W-1:0]  data_mem_q [DEPTH];

    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [N-1:0]  en_out_q, en_out_d;
    logic [W-1:0]  d_out_q, d_out_d;
    logic          addr_err_q, addr_err_d;

    logic          full, empty, push, pop;
    logic [AW-1:0] head_addr;
    logic [W-1:0]  head_data;

    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = !empty && !hold;
    assign head_addr = addr_mem_q[rd_ptr_q[PW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        en_out_d   = '0;
        d_out_d    = d_out_q;
        addr_err_d = addr_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            d_out_d  = head_data;
            // Out-of-range addresses match no bit, leaving the enable vector zero.
            for (int unsigned i = 0; i < N; i++) begin
                if ({1'b0, head_addr} == (AW+1)'(i)) begin
                    en_out_d[i] = 1'b1;
                end
            end
            if ({1'b0, head_addr} >= N_EXT) begin
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            en_out_q   <= '0;
            d_out_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            en_out_q   <= en_out_d;
            d_out_q    <= d_out_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage needs no reset: pointer reset alone discards queued entries.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q[PW-1:0]] <= in_addr;
            data_mem_q[wr_ptr_q[PW-1:0]] <= in_data;
        end
    end

    assign en_out   = en_out_q;
    assign d_out    = d_out_q;
    assign addr_err = addr_err_q;

`ifdef WRQ_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed and random checks of reg_write_queue against a queue-based reference model.
module tb_reg_write_queue;

    localparam int W     = 8;
    localparam int N     = 12;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [W-1:0]  in_data;
    logic          hold;
    logic [N-1:0]  en_out;
    logic [W-1:0]  d_out;
    logic          addr_err;
`ifdef WRQ_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    reg_write_queue #(.W(W), .N(N), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hold     (hold),
        .en_out   (en_out),
        .d_out    (d_out),
        .addr_err (addr_err)
`ifdef WRQ_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ent_t;

    ent_t          q[$];
    logic [N-1:0]  exp_en;
    logic [W-1:0]  exp_d;
    logic          exp_err;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: inputs driven away from the edge, model advanced, outputs sampled 1ns later.
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic h, input string tag);
        ent_t e;
        bit   do_pop, do_push;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        do_pop  = (q.size() > 0) && !h;
        do_push = v && (q.size() < DEPTH);
        exp_en  = '0;
        if (do_pop) begin
            e     = q.pop_front();
            exp_d = e.data;
            if (int'(e.addr) < N) exp_en = N'(1) << e.addr;
            else                  exp_err = 1'b1;
        end
        if (do_push) begin
            e.addr = a;
            e.data = d;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, ".en_out"},   32'(en_out),   32'(exp_en));
        chk({tag, ".d_out"},    32'(d_out),    32'(exp_d));
        chk({tag, ".addr_err"}, 32'(addr_err), 32'(exp_err));
`ifdef WRQ_LEVEL_EN
        chk({tag, ".level"},    32'(level),    32'(q.size()));
`endif
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        q.delete();
        exp_en   = '0;
        exp_d    = '0;
        exp_err  = 1'b0;
        #1;
        chk({tag, ".en_out"},   32'(en_out),   32'(0));
        chk({tag, ".d_out"},    32'(d_out),    32'(0));
        chk({tag, ".addr_err"}, 32'(addr_err), 32'(0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(1));
`ifdef WRQ_LEVEL_EN
        chk({tag, ".level"},    32'(level),    32'(0));
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        hold     = 1'b0;
        #2;
        do_reset("por");

        // Single write: pulse for exactly one cycle after the second edge.
        cycle(1'b1, 4'd3, 8'hA5, 1'b0, "single.push");
        chk("single.en_exact", 32'(en_out), 32'(0));
        cycle(1'b0, 4'd0, 8'h00, 1'b0, "single.pop");
        chk("single.en_exact", 32'(en_out), 32'h008);
        cycle(1'b0, 4'd0, 8'h00, 1'b0, "single.idle");

        // Fill under hold, fifth request refused, then drain in order.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, AW'(i + 5), W'(8'h10 + i), 1'b1, "fill");
        chk("fill.full_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 4'd0, 8'h00, 1'b0, "drain");

        // Sustained push+pop across pointer wrap.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, AW'($urandom_range(0, N - 1)), W'($urandom), 1'b0, "stream");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'd0, 8'h00, 1'b0, "stream.tail");

        // Reset with three entries queued: nothing drains afterwards.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, AW'(i + 1), W'($urandom), 1'b1, "prerst");
        do_reset("midrst");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 4'd0, 8'h00, 1'b0, "postrst");

        // Out-of-range address: no enable, sticky error.
        cycle(1'b1, 4'd13, 8'h3C, 1'b0, "oor.push");
        cycle(1'b1, 4'd11, 8'h5A, 1'b0, "oor.pop");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'd0, 8'h00, 1'b0, "oor.sticky");
        do_reset("oor.clear");

        // Random traffic with hold and occasional out-of-range addresses.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), W'($urandom),
                  1'($urandom_range(0, 3) == 0), "rand");
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b0, 4'd0, 8'h00, 1'b0, "rand.tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_write_queue.md
REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the register word length in bits.
REQ-002 The block SHALL have parameter N, default 16, meaning the number of registers in the downstream bank (2..2^AW).
REQ-003 The block SHALL have parameter AW, default 4, meaning the write address width.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the queue depth in entries (power of two, >=2).
REQ-005 The block SHALL have port clk  input  1  clock, rising-edge active.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port in_valid  input  1  write request present.
REQ-008 The block SHALL have port in_ready  output  1  queue can accept a request.
REQ-009 The block SHALL have port in_addr  input  AW  target register index.
REQ-010 The block SHALL have port in_data  input  W  write data.
REQ-011 The block SHALL have port hold  input  1  pause draining toward the bank.
REQ-012 The block SHALL have port en_out  output  N  one-hot per-register write enable to the bank.
REQ-013 The block SHALL have port d_out  output  W  write data broadcast to all registers of the bank.
REQ-014 The block SHALL have port addr_err  output  1  sticky flag: an out-of-range address was drained.

Function
REQ-015 Push SHALL occur on a rising clk edge when in_valid && in_ready; in_addr/in_data are stored at the tail.
REQ-016 in_ready SHALL be combinational and equal to !full; full means DEPTH entries are held.
REQ-017 While full, push SHALL be refused even if a pop occurs in the same cycle (no pass-through).
REQ-018 Pop SHALL occur on a rising edge when the queue is not empty and hold is low; one entry per cycle at most.
REQ-019 en_out and d_out SHALL be registered; on a pop edge, en_out = one-hot(head addr) and d_out = head data.
REQ-020 On any edge without a pop, en_out SHALL become all-zero and d_out SHALL keep its last value.
REQ-021 Each accepted entry SHALL produce exactly one cycle of en_out, in acceptance order.
REQ-022 Minimum latency: an entry pushed at edge k into an empty queue SHALL pop at edge k+1 (en_out valid in cycle after k+1).
REQ-023 Simultaneous push and pop when not full SHALL both occur; occupancy is unchanged.
REQ-024 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-025 A popped entry with addr >= N SHALL drive en_out all-zero and set addr_err, which stays set until reset.
REQ-026 hold asserted SHALL freeze the queue contents and never repeat a previous en_out pulse.

Reset
REQ-027 On rst low, pointers SHALL clear (queue empty), en_out = 0, d_out = 0, addr_err = 0, regardless of clk.
REQ-028 Reset mid-operation SHALL discard all queued entries; no en_out pulse SHALL follow reset release until a new push.
REQ-029 in_ready SHALL be 1 during and after reset.

Configuration
REQ-030 With macro WRQ_LEVEL_EN defined, the block SHALL add output level (width clog2(DEPTH)+1) giving current occupancy, 0 after reset, updated each edge per push/pop.
REQ-031 Without WRQ_LEVEL_EN, the level port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, push (addr 3, data 0xA5) at edge 1, hold low -> en_out = 0x0008, d_out = 0xA5 for exactly one cycle after edge 2.
REQ-033 hold high, push 4 entries -> in_ready drops to 0 after 4th push; 5th in_valid ignored; level = 4 if WRQ_LEVEL_EN.
REQ-034 Full queue, release hold -> 4 consecutive en_out pulses in push order, in_ready rises after first pop.
REQ-035 Continuous push+pop for 20 cycles, DEPTH=4 -> pointer wrap, no loss/duplication, order preserved.
REQ-036 N=12, push addr 13 -> en_out stays 0, addr_err = 1 and sticky until rst low.
REQ-037 Assert rst with 3 entries queued -> en_out = 0, in_ready = 1 immediately; no pulses after release.
